// File: rtl/mem_access_unit_if.sv
// Load/store request bus plus RAM port for mem_access_unit.
// The master side is the CPU datapath and RAM model; the slave side is the unit.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] ram_addr;
  logic [31:0] ram_rdata;
  logic        ram_we;
  logic [31:0] ram_wdata;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, ram_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, ram_addr, ram_we, ram_wdata
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, ram_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, ram_addr, ram_we, ram_wdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Byte/half/word load-store sequencer with read-modify-write for sub-word stores.
// Optional MEM_ACCESS_RANGE_CHECK_EN rejects word indices >= DEPTH_WORDS instead of wrapping.
module mem_access_unit #(
  parameter int DEPTH_WORDS = 64
) (
  input logic          clk,
  input logic          reset,
  mem_access_unit_if.slave bus
);

  localparam logic [31:0] ADDR_MASK = 32'((DEPTH_WORDS * 4) - 1) & ~32'd3;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t      r_state;
  logic        r_write;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [1:0]  r_lane;
  logic [31:0] r_wdata;
  logic        r_resp_valid;
  logic        r_resp_err;
  logic [31:0] r_resp_rdata;
  logic [31:0] r_ram_addr;
  logic        r_we;
  logic [31:0] r_ram_wdata;

  logic        w_bad_align;
  logic        w_bad_range;
  logic [31:0] w_aligned_addr;

  // NOTE: assign a default before the case so no path leaves the signal unassigned (no latch).
  always_comb begin
    w_bad_align = 1'b0;
    case (bus.req_size)
      2'b00:   w_bad_align = 1'b0;
      2'b01:   w_bad_align = bus.req_addr[0];
      2'b10:   w_bad_align = |bus.req_addr[1:0];
      default: w_bad_align = 1'b1;
    endcase
  end

`ifdef MEM_ACCESS_RANGE_CHECK_EN
  assign w_bad_range = (bus.req_addr[31:2] >= 30'(DEPTH_WORDS));
`else
  assign w_bad_range = 1'b0;
`endif

  // Masking also wraps out-of-range indices when the range check is disabled.
  assign w_aligned_addr = bus.req_addr & ADDR_MASK;

  function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] size,
                                          input logic [1:0] lane, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   res = {{24{b[7] & ~uns}}, b};
      2'b01:   res = {{16{h[15] & ~uns}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] word, input logic [31:0] data,
                                        input logic [1:0] size, input logic [1:0] lane);
    logic [31:0] res;
    res = word;
    if (size == 2'b00) begin
      case (lane)
        2'd0:    res[7:0]   = data[7:0];
        2'd1:    res[15:8]  = data[7:0];
        2'd2:    res[23:16] = data[7:0];
        default: res[31:24] = data[7:0];
      endcase
    end else if (size == 2'b01) begin
      if (lane[1]) res[31:16] = data[15:0];
      else         res[15:0]  = data[15:0];
    end else begin
      res = data;
    end
    return res;
  endfunction

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_write      <= 1'b0;
      r_size       <= 2'b00;
      r_unsigned   <= 1'b0;
      r_lane       <= 2'b00;
      r_wdata      <= 32'd0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= 32'd0;
      r_ram_addr   <= 32'd0;
      r_we         <= 1'b0;
      r_ram_wdata  <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_write    <= bus.req_write;
            r_size     <= bus.req_size;
            r_unsigned <= bus.req_unsigned;
            r_lane     <= bus.req_addr[1:0];
            r_wdata    <= bus.req_wdata;
            if (w_bad_align || w_bad_range) begin
              r_state      <= RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
            end else if (!bus.req_write || bus.req_size != 2'b10) begin
              r_state    <= READ;
              r_ram_addr <= w_aligned_addr;
            end else begin
              r_state     <= WRITE;
              r_we        <= 1'b1;
              r_ram_wdata <= bus.req_wdata;
              r_ram_addr  <= w_aligned_addr;
            end
          end
        end
        READ: begin
          if (!r_write) begin
            r_state      <= RESP;
            r_resp_valid <= 1'b1;
            r_resp_rdata <= extract(bus.ram_rdata, r_size, r_lane, r_unsigned);
            r_ram_addr   <= 32'd0;
          end else begin
            r_state     <= WRITE;
            r_we        <= 1'b1;
            r_ram_wdata <= merge(bus.ram_rdata, r_wdata, r_size, r_lane);
          end
        end
        WRITE: begin
          r_state      <= RESP;
          r_we         <= 1'b0;
          r_ram_wdata  <= 32'd0;
          r_ram_addr   <= 32'd0;
          r_resp_valid <= 1'b1;
        end
        RESP: begin
          r_state      <= IDLE;
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= 32'd0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Reset gates ready and write enable immediately so an abandoned store never commits.
  assign bus.req_ready  = (r_state == IDLE) && !reset;
  assign bus.ram_we     = r_we && !reset;
  assign bus.ram_addr   = r_ram_addr;
  assign bus.ram_wdata  = r_ram_wdata;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_err   = r_resp_err;
  assign bus.resp_rdata = r_resp_rdata;

endmodule
